// File: rtl/fl_hw_gen.sv
// Pseudo-random FrameLink frame generator driven by a 32-bit Galois LFSR.
// A software model seeded identically reproduces every frame bit-exactly.
module fl_hw_gen #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  CFG_VALID,
   output logic                  CFG_READY,
   input  logic [31:0]           CFG_SEED,
   input  logic [15:0]           CFG_FRAMES,
   input  logic [7:0]            CFG_MIN_LEN,
   input  logic [7:0]            CFG_MAX_LEN,
   input  logic                  CTRL_STOP,
   output logic [DATA_WIDTH-1:0] TX_DATA,
   output logic                  TX_SOF_N,
   output logic                  TX_EOF_N,
   output logic                  TX_SRC_RDY_N,
   input  logic                  TX_DST_RDY_N,
   output logic                  DONE,
   output logic [15:0]           FRAME_CNT
);

   localparam logic [1:0]  ST_IDLE   = 2'd0;
   localparam logic [1:0]  ST_LEN    = 2'd1;
   localparam logic [1:0]  ST_DATA   = 2'd2;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'd0);
   endfunction

   // span is never zero: the effective minimum is at least 1
   function automatic logic [7:0] draw_len(input logic [7:0] rnd,
                                           input logic [7:0] min_len,
                                           input logic [7:0] span);
      return min_len + (rnd % span);
   endfunction

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [31:0]           lfsr;
   logic [31:0]           lfsr_nxt;
   logic [7:0]            word_cnt;
   logic [7:0]            word_cnt_nxt;
   logic                  first_word;
   logic                  first_word_nxt;
   logic [7:0]            min_len;
   logic [7:0]            span;
   logic [15:0]           frames;
   logic                  stop_pend;
   logic [15:0]           frame_cnt;
   logic [15:0]           frame_cnt_inc;
   logic                  done;
   logic                  cfg_ready;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_sof_n;
   logic                  tx_eof_n;
   logic                  tx_src_rdy_n;

   logic [31:0]           cfg_seed_eff;
   logic [7:0]            cfg_min_eff;
   logic [7:0]            cfg_max_eff;
   logic [7:0]            cfg_span;
   logic                  cfg_accept;
   logic                  tx_accept;
   logic                  eof_accept;
   logic                  run_end;

   assign cfg_seed_eff = (CFG_SEED == 32'd0) ? 32'd1 : CFG_SEED;
   assign cfg_min_eff  = (CFG_MIN_LEN == 8'd0) ? 8'd1 : CFG_MIN_LEN;
   assign cfg_max_eff  = (CFG_MAX_LEN < cfg_min_eff) ? cfg_min_eff : CFG_MAX_LEN;
   assign cfg_span     = cfg_max_eff - cfg_min_eff + 8'd1;

   assign cfg_accept    = CFG_VALID && cfg_ready;
   assign tx_accept     = !tx_src_rdy_n && !TX_DST_RDY_N;
   assign eof_accept    = tx_accept && (word_cnt == 8'd1);
   assign frame_cnt_inc = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;
   // a stop arriving together with the final EOF still ends the run there
   assign run_end       = (frame_cnt_inc == frames) || stop_pend || CTRL_STOP;

   always_comb begin
      state_nxt      = state;
      lfsr_nxt       = lfsr;
      word_cnt_nxt   = word_cnt;
      first_word_nxt = first_word;
      case (state)
         ST_IDLE: begin
            if (cfg_accept) begin
               lfsr_nxt = cfg_seed_eff;
               if (CFG_FRAMES != 16'd0) state_nxt = ST_LEN;
            end
         end
         ST_LEN: begin
            word_cnt_nxt   = draw_len(lfsr[7:0], min_len, span);
            lfsr_nxt       = lfsr_step(lfsr);
            first_word_nxt = 1'b1;
            state_nxt      = ST_DATA;
         end
         ST_DATA: begin
            if (tx_accept) begin
               lfsr_nxt       = lfsr_step(lfsr);
               word_cnt_nxt   = word_cnt - 8'd1;
               first_word_nxt = 1'b0;
               if (word_cnt == 8'd1) state_nxt = run_end ? ST_IDLE : ST_LEN;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // TX outputs are registered from the next-state view so that they line up
   // with the state register and hold automatically while the sink stalls.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= ST_IDLE;
         lfsr         <= 32'd1;
         word_cnt     <= 8'd0;
         first_word   <= 1'b0;
         stop_pend    <= 1'b0;
         frame_cnt    <= 16'd0;
         done         <= 1'b0;
         cfg_ready    <= 1'b1;
         tx_data      <= '0;
         tx_sof_n     <= 1'b1;
         tx_eof_n     <= 1'b1;
         tx_src_rdy_n <= 1'b1;
      end else begin
         state        <= state_nxt;
         lfsr         <= lfsr_nxt;
         word_cnt     <= word_cnt_nxt;
         first_word   <= first_word_nxt;
         cfg_ready    <= (state_nxt == ST_IDLE);
         tx_src_rdy_n <= (state_nxt != ST_DATA);
         if (state_nxt == ST_DATA) begin
            tx_data  <= lfsr_nxt[DATA_WIDTH-1:0];
            tx_sof_n <= !first_word_nxt;
            tx_eof_n <= (word_cnt_nxt != 8'd1);
         end else begin
            tx_sof_n <= 1'b1;
            tx_eof_n <= 1'b1;
         end

         if (state_nxt == ST_IDLE) begin
            stop_pend <= 1'b0;
         end else if (CTRL_STOP && (state != ST_IDLE)) begin
            stop_pend <= 1'b1;
         end

         if (cfg_accept) begin
            frame_cnt <= 16'd0;
            done      <= (CFG_FRAMES == 16'd0);
         end else if (eof_accept) begin
            frame_cnt <= frame_cnt_inc;
            if (run_end) done <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (cfg_accept) begin
         min_len <= cfg_min_eff;
         span    <= cfg_span;
         frames  <= CFG_FRAMES;
      end
   end

   assign CFG_READY    = cfg_ready;
   assign TX_DATA      = tx_data;
   assign TX_SOF_N     = tx_sof_n;
   assign TX_EOF_N     = tx_eof_n;
   assign TX_SRC_RDY_N = tx_src_rdy_n;
   assign DONE         = done;
   assign FRAME_CNT    = frame_cnt;

endmodule
